// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C command sequencer: the command-entry
// layout, the fixed power-up command table and the one-hot state encodings.
package i2c_seq_pkg;

    localparam int MAX_TRANSFER_DEFAULT = 4;
    localparam int NUM_CMDS_DEFAULT     = 6;
    localparam int LEN_W                = $clog2(MAX_TRANSFER_DEFAULT + 1);
    localparam int DATA_W               = MAX_TRANSFER_DEFAULT * 8;

    // One I2C transaction: target address, byte counts and bytes to write.
    typedef struct packed {
        logic [6:0]        addr;
        logic [LEN_W-1:0]  wrLen;
        logic [LEN_W-1:0]  rdLen;
        logic [DATA_W-1:0] wrData;
    } cmd_entry_t;

    // Power-up command list, executed in order once per pass.
    localparam cmd_entry_t CMD_TABLE [NUM_CMDS_DEFAULT] = '{
        '{addr: 7'h2D, wrLen: 3'd1, rdLen: 3'd2, wrData: 32'h0000_001C},
        '{addr: 7'h2D, wrLen: 3'd2, rdLen: 3'd0, wrData: 32'h0000_8003},
        '{addr: 7'h48, wrLen: 3'd1, rdLen: 3'd1, wrData: 32'h0000_0005},
        '{addr: 7'h48, wrLen: 3'd3, rdLen: 3'd0, wrData: 32'h0012_3401},
        '{addr: 7'h50, wrLen: 3'd4, rdLen: 3'd0, wrData: 32'hDEAD_BEEF},
        '{addr: 7'h50, wrLen: 3'd1, rdLen: 3'd4, wrData: 32'h0000_0010}
    };

    localparam int STATE_W = 8;
    localparam logic [STATE_W-1:0] S_DELAY     = 8'b0000_0001;
    localparam logic [STATE_W-1:0] S_ISSUE     = 8'b0000_0010;
    localparam logic [STATE_W-1:0] S_WAIT_BUSY = 8'b0000_0100;
    localparam logic [STATE_W-1:0] S_WAIT_DONE = 8'b0000_1000;
    localparam logic [STATE_W-1:0] S_CHECK     = 8'b0001_0000;
    localparam logic [STATE_W-1:0] S_NEXT      = 8'b0010_0000;
    localparam logic [STATE_W-1:0] S_DONE      = 8'b0100_0000;
    localparam logic [STATE_W-1:0] S_ERROR     = 8'b1000_0000;

    // True while a transaction descriptor must be presented to the master.
    function automatic logic isInFlight(input logic [STATE_W-1:0] st);
        return (st & (S_ISSUE | S_WAIT_BUSY | S_WAIT_DONE)) != '0;
    endfunction

endpackage

// File: rtl/i2c_seq_cmd_rom.sv
// Combinational lookup of one command-table entry; indices past the end of
// the table (or past NUM_CMDS) read back as an all-zero entry.
module i2c_seq_cmd_rom
    import i2c_seq_pkg::*;
#(
    parameter int NUM_CMDS = NUM_CMDS_DEFAULT
) (
    input  logic [2:0] index_i,
    output cmd_entry_t entry_o
);

    // Table read with a zero default for unused indices.
    always_comb begin
        entry_o = '0;
        if ((int'(index_i) < NUM_CMDS) && (int'(index_i) < NUM_CMDS_DEFAULT)) begin
            entry_o = CMD_TABLE[index_i];
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Walks the command table after a start-up delay, handing each entry to an
// i2c_master and retrying entries that get no response.
// Optional build macro: I2C_SEQ_REPEAT_EN -- when defined, the table is
// re-run REPEAT_DELAY cycles after each completed pass; otherwise DONE is
// terminal until reset.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int MAX_TRANSFER  = MAX_TRANSFER_DEFAULT,
    parameter int NUM_CMDS      = NUM_CMDS_DEFAULT,
    parameter int STARTUP_DELAY = 500,
    parameter int RETRY_LIMIT   = 3,
    parameter int BUSY_TIMEOUT  = 255,
    parameter int REPEAT_DELAY  = 100000
) (
    input  logic                               clk_48mhz,
    input  logic                               i2c_rst,
    input  logic                               enable,
    output logic [6:0]                         i2c_address,
    output logic [MAX_TRANSFER*8-1:0]          write_data,
    output logic [$clog2(MAX_TRANSFER+1)-1:0]  write_transfer_length,
    output logic [$clog2(MAX_TRANSFER+1)-1:0]  read_transfer_length,
    output logic                               start,
    input  logic                               busy,
    input  logic                               complete,
    input  logic                               no_response,
    input  logic [MAX_TRANSFER*8-1:0]          read_data,
    output logic [31:0]                        status_data,
    output logic [2:0]                         cmd_index,
    output logic                               seq_done,
    output logic                               seq_error
);

    localparam int XFER_W  = MAX_TRANSFER * 8;
    localparam int LW      = $clog2(MAX_TRANSFER + 1);
    localparam int CNT_A   = (STARTUP_DELAY > BUSY_TIMEOUT) ? STARTUP_DELAY : BUSY_TIMEOUT;
    localparam int CNT_MAX = (CNT_A > REPEAT_DELAY) ? CNT_A : REPEAT_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   delayCnt_q, delayCnt_d;
    logic               start_q, start_d;
    logic [2:0]         cmdIdx_q, cmdIdx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [31:0]        status_q, status_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               timedOut_q, timedOut_d;
    cmd_entry_t         romEntry;

    i2c_seq_cmd_rom #(
        .NUM_CMDS (NUM_CMDS)
    ) u_cmd_rom (
        .index_i (cmdIdx_q),
        .entry_o (romEntry)
    );

    // Next-state logic; one counter is shared by start-up delay, busy timeout and repeat delay.
    always_comb begin
        state_d    = state_q;
        delayCnt_d = delayCnt_q;
        start_d    = start_q;
        cmdIdx_d   = cmdIdx_q;
        retry_d    = retry_q;
        status_d   = status_q;
        done_d     = done_q;
        error_d    = error_q;
        timedOut_d = timedOut_q;
        case (state_q)
            S_DELAY: begin
                if (!enable) begin
                    delayCnt_d = CNT_W'(STARTUP_DELAY);
                end else if (delayCnt_q == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    delayCnt_d = delayCnt_q - CNT_W'(1);
                end
            end
            S_ISSUE: begin
                start_d    = 1'b1;
                timedOut_d = 1'b0;
                delayCnt_d = CNT_W'(BUSY_TIMEOUT - 1);
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (delayCnt_q == '0) begin
                    start_d    = 1'b0;
                    timedOut_d = 1'b1;
                    state_d    = S_CHECK;
                end else begin
                    delayCnt_d = delayCnt_q - CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!busy) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Anything other than a clean completion (including no status at all) counts as a failed attempt.
                if (!timedOut_q && complete && !no_response) begin
                    if (romEntry.rdLen != '0) begin
                        status_d = 32'(read_data);
                    end
                    retry_d = '0;
                    state_d = S_NEXT;
                end else if (retry_q < RETRY_W'(RETRY_LIMIT)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_ISSUE;
                end else begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_NEXT: begin
                if (cmdIdx_q == 3'(NUM_CMDS - 1)) begin
                    done_d     = 1'b1;
                    delayCnt_d = CNT_W'(REPEAT_DELAY - 1);
                    state_d    = S_DONE;
                end else begin
                    cmdIdx_d = cmdIdx_q + 3'd1;
                    state_d  = S_ISSUE;
                end
            end
            S_DONE: begin
`ifdef I2C_SEQ_REPEAT_EN
                if (delayCnt_q == '0) begin
                    done_d   = 1'b0;
                    cmdIdx_d = '0;
                    retry_d  = '0;
                    state_d  = S_ISSUE;
                end else begin
                    delayCnt_d = delayCnt_q - CNT_W'(1);
                end
`else
                state_d = S_DONE;
`endif
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                error_d = 1'b1;
                start_d = 1'b0;
                state_d = S_ERROR;
            end
        endcase
    end

    // State registers with asynchronous return to the start-up delay.
    always_ff @(posedge clk_48mhz or posedge i2c_rst) begin
        if (i2c_rst) begin
            state_q    <= S_DELAY;
            delayCnt_q <= CNT_W'(STARTUP_DELAY);
            start_q    <= 1'b0;
            cmdIdx_q   <= '0;
            retry_q    <= '0;
            status_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            timedOut_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            delayCnt_q <= delayCnt_d;
            start_q    <= start_d;
            cmdIdx_q   <= cmdIdx_d;
            retry_q    <= retry_d;
            status_q   <= status_d;
            done_q     <= done_d;
            error_q    <= error_d;
            timedOut_q <= timedOut_d;
        end
    end

    // Descriptor is the current table entry while a transaction is open, zero otherwise.
    always_comb begin
        i2c_address           = '0;
        write_data            = '0;
        write_transfer_length = '0;
        read_transfer_length  = '0;
        if (isInFlight(state_q)) begin
            i2c_address           = romEntry.addr;
            write_data            = XFER_W'(romEntry.wrData);
            write_transfer_length = LW'(romEntry.wrLen);
            read_transfer_length  = LW'(romEntry.rdLen);
        end
    end

    assign start       = start_q;
    assign cmd_index   = cmdIdx_q;
    assign status_data = status_q;
    assign seq_done    = done_q;
    assign seq_error   = error_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural i2c_master and a
// scoreboard of expected command descriptors.
module tb_i2c_cmd_sequencer;

    localparam int MAX_TRANSFER  = 4;
    localparam int NUM_CMDS      = 6;
    localparam int STARTUP_DELAY = 500;
    localparam int RETRY_LIMIT   = 3;
    localparam int BUSY_TIMEOUT  = 255;
    localparam int REPEAT_DELAY  = 300;

    logic        clk_48mhz = 1'b0;
    logic        i2c_rst = 1'b1;
    logic        enable = 1'b0;
    logic        busy = 1'b0;
    logic        complete = 1'b0;
    logic        no_response = 1'b0;
    logic [31:0] read_data = '0;
    logic [6:0]  i2c_address;
    logic [31:0] write_data;
    logic [2:0]  write_transfer_length;
    logic [2:0]  read_transfer_length;
    logic        start;
    logic [31:0] status_data;
    logic [2:0]  cmd_index;
    logic        seq_done;
    logic        seq_error;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wrLen;
        logic [31:0] rdLen;
        logic [31:0] wrData;
    } tbEntry_t;

    int   checks = 0;
    int   failures = 0;
    int   startCount = 0;
    int   idx2Starts = 0;
    int   nackIdx = -1;
    logic neverBusy = 1'b0;
    int   expQ[$];
    int   mState = 0;
    int   mCnt = 0;
    int   curIdx = 0;
    int   curExp = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    i2c_cmd_sequencer #(
        .MAX_TRANSFER  (MAX_TRANSFER),
        .NUM_CMDS      (NUM_CMDS),
        .STARTUP_DELAY (STARTUP_DELAY),
        .RETRY_LIMIT   (RETRY_LIMIT),
        .BUSY_TIMEOUT  (BUSY_TIMEOUT),
        .REPEAT_DELAY  (REPEAT_DELAY)
    ) dut (
        .clk_48mhz             (clk_48mhz),
        .i2c_rst               (i2c_rst),
        .enable                (enable),
        .i2c_address           (i2c_address),
        .write_data            (write_data),
        .write_transfer_length (write_transfer_length),
        .read_transfer_length  (read_transfer_length),
        .start                 (start),
        .busy                  (busy),
        .complete              (complete),
        .no_response           (no_response),
        .read_data             (read_data),
        .status_data           (status_data),
        .cmd_index             (cmd_index),
        .seq_done              (seq_done),
        .seq_error             (seq_error)
    );

    // Expected command table, independent of the design package.
    function automatic tbEntry_t expEntry(input int i);
        case (i)
            0:       return '{32'h2D, 32'd1, 32'd2, 32'h0000_001C};
            1:       return '{32'h2D, 32'd2, 32'd0, 32'h0000_8003};
            2:       return '{32'h48, 32'd1, 32'd1, 32'h0000_0005};
            3:       return '{32'h48, 32'd3, 32'd0, 32'h0012_3401};
            4:       return '{32'h50, 32'd4, 32'd0, 32'hDEAD_BEEF};
            5:       return '{32'h50, 32'd1, 32'd4, 32'h0000_0010};
            default: return '0;
        endcase
    endfunction

    // Read data the master model returns; zero-length reads get junk that must be ignored.
    function automatic logic [31:0] modelRead(input int i);
        case (i)
            0:       return 32'h0000_A55A;
            2:       return 32'h0000_00C3;
            5:       return 32'h1122_3344;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkDescriptor(input string phase, input int e);
        tbEntry_t x;
        x = expEntry(e);
        checkOutput({phase, "_addr"},   32'(i2c_address),           x.addr);
        checkOutput({phase, "_wrlen"},  32'(write_transfer_length), x.wrLen);
        checkOutput({phase, "_rdlen"},  32'(read_transfer_length),  x.rdLen);
        checkOutput({phase, "_wrdata"}, write_data,                 x.wrData);
    endtask

    // Hold reset, configure the master model, clear the scoreboard and check reset values.
    task automatic applyStimulus(input logic en, input int nack, input logic noBusy);
        i2c_rst = 1'b1;
        enable = en;
        nackIdx = nack;
        neverBusy = noBusy;
        repeat (3) @(negedge clk_48mhz);
        expQ.delete();
        startCount = 0;
        idx2Starts = 0;
        checkOutput("rst_start",     32'(start),       32'd0);
        checkOutput("rst_cmd_index", 32'(cmd_index),   32'd0);
        checkOutput("rst_seq_done",  32'(seq_done),    32'd0);
        checkOutput("rst_seq_error", 32'(seq_error),   32'd0);
        checkOutput("rst_status",    status_data,      32'd0);
        checkOutput("rst_address",   32'(i2c_address), 32'd0);
    endtask

    // Behavioural i2c_master: two cycles to busy, three cycles busy, status held until next start.
    initial begin : masterModel
        forever begin
            @(negedge clk_48mhz);
            if (i2c_rst) begin
                busy = 1'b0;
                complete = 1'b0;
                no_response = 1'b0;
                mState = 0;
            end else begin
                case (mState)
                    0: if (start) begin
                        startCount++;
                        curIdx = int'(cmd_index);
                        if (curIdx == 2) idx2Starts++;
                        complete = 1'b0;
                        no_response = 1'b0;
                        checkOutput("sb_start_expected", 32'(expQ.size() > 0), 32'd1);
                        if (expQ.size() > 0) begin
                            curExp = expQ.pop_front();
                            checkDescriptor("issue", curExp);
                        end
                        if (neverBusy) begin
                            mState = 4;
                        end else begin
                            mState = 1;
                            mCnt = 2;
                        end
                    end
                    1: begin
                        mCnt--;
                        if (mCnt == 0) begin
                            busy = 1'b1;
                            mState = 2;
                            mCnt = 3;
                        end
                    end
                    2: begin
                        mCnt--;
                        if (mCnt == 1) begin
                            checkDescriptor("held", curExp);
                            if (curIdx != nackIdx) begin
                                complete = 1'b1;
                                read_data = modelRead(curIdx);
                            end
                        end
                        if (mCnt == 0) begin
                            busy = 1'b0;
                            if (curIdx == nackIdx) no_response = 1'b1;
                            else complete = 1'b1;
                            mState = 0;
                        end
                    end
                    4: if (!start) mState = 0;
                    default: mState = 0;
                endcase
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : directedSteps
        int cyc;
        int w;

        // Normal pass: start-up latency, descriptors in order, status capture, done.
        applyStimulus(1'b1, -1, 1'b0);
        for (int i = 0; i < NUM_CMDS; i++) expQ.push_back(i);
        i2c_rst = 1'b0;
        cyc = 0;
        while (!start && cyc < STARTUP_DELAY + 50) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("start_latency", 32'(cyc), 32'(STARTUP_DELAY + 2));
        cyc = 0;
        while (cmd_index != 3'd1 && cyc < 200) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("reach_idx1", 32'(cmd_index), 32'd1);
        checkOutput("status_after_e0", status_data, 32'h0000_A55A);
        cyc = 0;
        while (cmd_index != 3'd2 && cyc < 200) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("status_kept_e1", status_data, 32'h0000_A55A);
        cyc = 0;
        while (!seq_done && cyc < 1000) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("pass_done",      32'(seq_done),    32'd1);
        checkOutput("done_index",     32'(cmd_index),   32'd5);
        checkOutput("done_status",    status_data,      32'h1122_3344);
        checkOutput("done_starts",    32'(startCount),  32'd6);
        checkOutput("done_sb_empty",  32'(expQ.size()), 32'd0);
        checkOutput("done_no_error",  32'(seq_error),   32'd0);
        checkOutput("done_addr_zero", 32'(i2c_address), 32'd0);
        checkOutput("done_wd_zero",   write_data,       32'd0);
`ifdef I2C_SEQ_REPEAT_EN
        for (int i = 0; i < NUM_CMDS; i++) expQ.push_back(i);
        cyc = 0;
        while (!start && cyc < REPEAT_DELAY + 50) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("repeat_latency", 32'(cyc), 32'(REPEAT_DELAY + 1));
        checkOutput("repeat_done_cleared", 32'(seq_done), 32'd0);
        cyc = 0;
        while (!seq_done && cyc < 1000) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("repeat_pass_done", 32'(seq_done), 32'd1);
        checkOutput("repeat_starts", 32'(startCount), 32'd12);
`else
        repeat (2 * REPEAT_DELAY) @(negedge clk_48mhz);
        checkOutput("no_repeat_starts", 32'(startCount), 32'd6);
        checkOutput("no_repeat_done",   32'(seq_done),   32'd1);
        checkOutput("no_repeat_start",  32'(start),      32'd0);
`endif

        // Entry 2 never answers: four attempts, then a sticky error.
        applyStimulus(1'b1, 2, 1'b0);
        expQ.push_back(0);
        expQ.push_back(1);
        for (int i = 0; i <= RETRY_LIMIT; i++) expQ.push_back(2);
        i2c_rst = 1'b0;
        cyc = 0;
        while (!seq_error && cyc < 2000) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("nack_error",     32'(seq_error),  32'd1);
        checkOutput("nack_index",     32'(cmd_index),  32'd2);
        checkOutput("nack_e2_starts", 32'(idx2Starts), 32'(RETRY_LIMIT + 1));
        checkOutput("nack_no_done",   32'(seq_done),   32'd0);
        repeat (300) @(negedge clk_48mhz);
        checkOutput("nack_sticky_starts", 32'(startCount),  32'd6);
        checkOutput("nack_sb_empty",      32'(expQ.size()), 32'd0);
        checkOutput("nack_still_error",   32'(seq_error),   32'd1);

        // Master never goes busy: start held for the timeout, each timeout is one retry.
        applyStimulus(1'b1, -1, 1'b1);
        for (int i = 0; i <= RETRY_LIMIT; i++) expQ.push_back(0);
        i2c_rst = 1'b0;
        cyc = 0;
        while (!start && cyc < STARTUP_DELAY + 50) begin @(negedge clk_48mhz); cyc++; end
        w = 0;
        while (start && w < 1000) begin w++; @(negedge clk_48mhz); end
        checkOutput("timeout_start_width", 32'(w), 32'(BUSY_TIMEOUT));
        cyc = 0;
        while (!seq_error && cyc < 3000) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("timeout_error",  32'(seq_error),  32'd1);
        checkOutput("timeout_starts", 32'(startCount), 32'(RETRY_LIMIT + 1));
        checkOutput("timeout_index",  32'(cmd_index),  32'd0);

        // Reset while entry 3 is in WAIT_DONE, then a clean restart from entry 0.
        applyStimulus(1'b1, -1, 1'b0);
        for (int i = 0; i < 4; i++) expQ.push_back(i);
        i2c_rst = 1'b0;
        cyc = 0;
        while (!(cmd_index == 3'd3 && busy && !start) && cyc < 1500) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("midxfer_reached", 32'(cmd_index), 32'd3);
        checkOutput("midxfer_sb_empty", 32'(expQ.size()), 32'd0);
        i2c_rst = 1'b1;
        #1;
        checkOutput("async_start",  32'(start),       32'd0);
        checkOutput("async_index",  32'(cmd_index),   32'd0);
        checkOutput("async_addr",   32'(i2c_address), 32'd0);
        applyStimulus(1'b1, -1, 1'b0);
        for (int i = 0; i < NUM_CMDS; i++) expQ.push_back(i);
        i2c_rst = 1'b0;
        cyc = 0;
        while (!start && cyc < STARTUP_DELAY + 50) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("restart_latency", 32'(cyc), 32'(STARTUP_DELAY + 2));
        cyc = 0;
        while (!seq_done && cyc < 1000) begin @(negedge clk_48mhz); cyc++; end
        checkOutput("restart_done",   32'(seq_done),   32'd1);
        checkOutput("restart_starts", 32'(startCount), 32'd6);
        checkOutput("restart_status", status_data,     32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
